// File: rtl/multicycle_controller_if.sv
// ALU control/flag bundle between the multicycle controller (master) and the ALU (slave).
interface multicycle_controller_if #(
    parameter int ALUC_W = 3
);
    logic [ALUC_W-1:0] alucontrol;
    logic              Z;
    logic              N;
    logic              C;
    logic              V;

    modport master (output alucontrol, input Z, N, C, V);
    modport slave  (input alucontrol, output Z, N, C, V);
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute, drives datapath selects
// and enables, issues the ALU control code and resolves branches from the ALU flags.
module multicycle_controller #(
    parameter int ALUC_W = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              op,
    input  logic [2:0]              funct3,
    input  logic                    funct7b5,
    multicycle_controller_if.master alu,
    output logic                    pcwrite,
    output logic                    adrsrc,
    output logic                    memwrite,
    output logic                    irwrite,
    output logic [1:0]              resultsrc,
    output logic [1:0]              alusrca,
    output logic [1:0]              alusrcb,
    output logic [1:0]              immsrc,
    output logic                    regwrite,
    output logic                    illegal,
    output logic [3:0]              state_dbg
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(0);
    localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(1);
    localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(2);
    localparam logic [ALUC_W-1:0] ALU_OR  = ALUC_W'(3);
    localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(5);

    typedef struct packed {
        logic              adrsrc;
        logic              irwrite;
        logic              pcwrite;
        logic              memwrite;
        logic              regwrite;
        logic [1:0]        resultsrc;
        logic [1:0]        alusrca;
        logic [1:0]        alusrcb;
        logic [ALUC_W-1:0] alucontrol;
    } ctrl_t;

    state_t            state;
    state_t            nxt;
    ctrl_t             ctrl;
    logic [ALUC_W-1:0] aludec;
    logic              taken;
    logic              unused_c;

    function automatic logic alu_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic br_f3_ok(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

    // Unsupported op/funct3 combinations fall back to FETCH straight from DECODE.
    function automatic state_t next_state(input state_t s, input logic [6:0] o,
                                          input logic [2:0] f3);
        state_t n;
        n = FETCH;
        case (s)
            FETCH:    n = DECODE;
            DECODE: begin
                case (o)
                    OP_LW, OP_SW: n = MEMADR;
                    OP_R:         n = alu_f3_ok(f3) ? EXEC_R : FETCH;
                    OP_I:         n = alu_f3_ok(f3) ? EXEC_I : FETCH;
                    OP_BR:        n = br_f3_ok(f3) ? BRANCH : FETCH;
                    OP_JAL:       n = JAL;
                    default:      n = FETCH;
                endcase
            end
            MEMADR:   n = (o == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  n = MEMWB;
            EXEC_R:   n = ALUWB;
            EXEC_I:   n = ALUWB;
            JAL:      n = ALUWB;
            default:  n = FETCH;
        endcase
        return n;
    endfunction

    function automatic ctrl_t moore(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.irwrite   = 1'b1;
                c.pcwrite   = 1'b1;
                c.alusrcb   = 2'b10;
                c.resultsrc = 2'b10;
            end
            DECODE: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b01;
            end
            MEMADR: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
            end
            MEMREAD:  c.adrsrc = 1'b1;
            MEMWB: begin
                c.resultsrc = 2'b01;
                c.regwrite  = 1'b1;
            end
            MEMWRITE: begin
                c.adrsrc   = 1'b1;
                c.memwrite = 1'b1;
            end
            EXEC_R:   c.alusrca = 2'b10;
            EXEC_I: begin
                c.alusrca = 2'b10;
                c.alusrcb = 2'b01;
            end
            ALUWB:    c.regwrite = 1'b1;
            BRANCH: begin
                c.alusrca    = 2'b10;
                c.alucontrol = ALU_SUB;
            end
            JAL: begin
                c.alusrca = 2'b01;
                c.alusrcb = 2'b10;
                c.pcwrite = 1'b1;
            end
            default:  c = '0;
        endcase
        return c;
    endfunction

    assign nxt = next_state(state, op, funct3);

    // Outputs are registered as the Moore decode of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            ctrl  <= moore(FETCH);
        end else begin
            state <= nxt;
            ctrl  <= moore(nxt);
        end
    end

    always_comb begin
        aludec = ALU_ADD;
        case (funct3)
            3'b000:  aludec = ((op == OP_R) && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  aludec = ALU_SLT;
            3'b110:  aludec = ALU_OR;
            3'b111:  aludec = ALU_AND;
            default: aludec = ALU_ADD;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = alu.Z;
            3'b001:  taken = ~alu.Z;
            3'b100:  taken = alu.N ^ alu.V;
            3'b101:  taken = ~(alu.N ^ alu.V);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        immsrc = 2'b00;
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BR:   immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    // Write enables are gated by rst_n so an asynchronous reset can never leave one high.
    assign pcwrite        = rst_n & (ctrl.pcwrite | ((state == BRANCH) & taken));
    assign irwrite        = rst_n & ctrl.irwrite;
    assign regwrite       = rst_n & ctrl.regwrite;
    assign memwrite       = rst_n & ctrl.memwrite;
    assign adrsrc         = ctrl.adrsrc;
    assign resultsrc      = ctrl.resultsrc;
    assign alusrca        = ctrl.alusrca;
    assign alusrcb        = ctrl.alusrcb;
    assign alu.alucontrol = ((state == EXEC_R) || (state == EXEC_I)) ? aludec : ctrl.alucontrol;
    assign illegal        = rst_n & (state == DECODE) & (nxt == FETCH);
    assign state_dbg      = state;
    assign unused_c       = alu.C;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction cycle model driven by random
// instructions and operands, plus directed reset, lw, sub/addi, branch and illegal scenarios.
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [3:0] FETCH_CODE = 4'd0;

    // {pcwrite, irwrite, regwrite, memwrite, illegal, adrsrc, resultsrc, alusrca, alusrcb, alucontrol, immsrc}
    typedef logic [16:0] vec_t;
    typedef struct packed {
        vec_t v;
        vec_t m;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic       regwrite;
    logic       illegal;
    logic [3:0] state_dbg;

    int   checks;
    int   errors;
    exp_t exp_q[$];
    vec_t obs_q[$];

    multicycle_controller_if #(.ALUC_W(3)) bus ();

    multicycle_controller #(.ALUC_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .alu       (bus),
        .pcwrite   (pcwrite),
        .adrsrc    (adrsrc),
        .memwrite  (memwrite),
        .irwrite   (irwrite),
        .resultsrc (resultsrc),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .immsrc    (immsrc),
        .regwrite  (regwrite),
        .illegal   (illegal),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A negative argument marks that field as don't-care for the cycle.
    function automatic exp_t mk(input int pcw, input int irw, input int regw, input int memw,
                                input int ill, input int adr, input int res, input int sa,
                                input int sb, input int ac, input int imm);
        exp_t e;
        e.v = {pcw[0], irw[0], regw[0], memw[0], ill[0], adr[0], res[1:0], sa[1:0], sb[1:0],
               ac[2:0], imm[1:0]};
        e.m = {5'b11111, (adr >= 0), {2{res >= 0}}, {2{sa >= 0}}, {2{sb >= 0}}, {3{ac >= 0}},
               {2{imm >= 0}}};
        return e;
    endfunction

    function automatic vec_t sample();
        return {pcwrite, irwrite, regwrite, memwrite, illegal, adrsrc, resultsrc, alusrca,
                alusrcb, bus.alucontrol, immsrc};
    endfunction

    // Builds the expected per-cycle control vectors of one instruction from its class.
    task automatic model(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b);
        int imm;
        int ac;
        int tk;
        bit legal;
        exp_q.delete();
        imm = (o == OP_LW || o == OP_I) ? 0 : (o == OP_SW) ? 1 : (o == OP_BR) ? 2 :
              (o == OP_JAL) ? 3 : -1;
        legal = (o == OP_LW) || (o == OP_SW) || (o == OP_JAL) ||
                ((o == OP_R || o == OP_I) && (f3 inside {3'b000, 3'b010, 3'b110, 3'b111})) ||
                ((o == OP_BR) && (f3 inside {3'b000, 3'b001, 3'b100, 3'b101}));
        case (f3)
            3'b000:  tk = (a == b) ? 1 : 0;
            3'b001:  tk = (a != b) ? 1 : 0;
            3'b100:  tk = ($signed(a) < $signed(b)) ? 1 : 0;
            3'b101:  tk = ($signed(a) >= $signed(b)) ? 1 : 0;
            default: tk = 0;
        endcase
        ac = (f3 == 3'b000) ? (((o == OP_R) && f7) ? 1 : 0) : (f3 == 3'b010) ? 5 :
             (f3 == 3'b110) ? 3 : 2;
        exp_q.push_back(mk(1, 1, 0, 0, 0, 0, 2, 0, 2, 0, imm));
        exp_q.push_back(mk(0, 0, 0, 0, legal ? 0 : 1, -1, -1, 1, 1, 0, imm));
        if (!legal) return;
        if (o == OP_LW || o == OP_SW) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, -1, -1, 2, 1, 0, imm));
            if (o == OP_LW) begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0, -1, -1, -1, imm));
                exp_q.push_back(mk(0, 0, 1, 0, 0, -1, 1, -1, -1, -1, imm));
            end else begin
                exp_q.push_back(mk(0, 0, 0, 1, 0, 1, 0, -1, -1, -1, imm));
            end
        end else if (o == OP_R || o == OP_I) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, -1, -1, 2, (o == OP_R) ? 0 : 1, ac, imm));
            exp_q.push_back(mk(0, 0, 1, 0, 0, -1, 0, -1, -1, -1, imm));
        end else if (o == OP_BR) begin
            exp_q.push_back(mk(tk, 0, 0, 0, 0, -1, 0, 2, 0, 1, imm));
        end else begin
            exp_q.push_back(mk(1, 0, 0, 0, 0, -1, 0, 1, 2, 0, imm));
            exp_q.push_back(mk(0, 0, 1, 0, 0, -1, 0, -1, -1, -1, imm));
        end
    endtask

    task automatic set_flags(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] d;
        d = a - b;
        bus.Z = (d == 32'd0);
        bus.N = d[31];
        bus.V = (a[31] != b[31]) && (d[31] != a[31]);
        bus.C = (a >= b);
    endtask

    // Runs one instruction for as many cycles as the model predicts, recording outputs.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic [31:0] a, input logic [31:0] b);
        model(o, f3, f7, a, b);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        set_flags(a, b);
        obs_q.delete();
        for (int i = 0; i < exp_q.size(); i++) begin
            #1;
            obs_q.push_back(sample());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (state_dbg !== FETCH_CODE) begin
            errors++;
            $display("[TB] FAIL reset_state: got %0d expected %0d", state_dbg, FETCH_CODE);
        end
        checks++;
        if ({pcwrite, irwrite, regwrite, memwrite} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_enables: got %b expected 0000",
                     {pcwrite, irwrite, regwrite, memwrite});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({irwrite, pcwrite} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL release_fetch: got irwrite,pcwrite=%b expected 11",
                     {irwrite, pcwrite});
        end
        op       = OP_R;
        funct3   = 3'b000;
        funct7b5 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if ({alusrca, bus.alucontrol} !== {2'b10, 3'b001}) begin
            errors++;
            $display("[TB] FAIL pre_reset_exec_r: got srca,aluctl=%b expected 10001",
                     {alusrca, bus.alucontrol});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state_dbg, pcwrite, irwrite, regwrite, memwrite} !== {FETCH_CODE, 4'b0000}) begin
            errors++;
            $display("[TB] FAIL mid_reset_immediate: got state=%0d en=%b expected 0 0000",
                     state_dbg, {pcwrite, irwrite, regwrite, memwrite});
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({state_dbg, pcwrite, irwrite, regwrite, memwrite} !== {FETCH_CODE, 4'b0000}) begin
                errors++;
                $display("[TB] FAIL mid_reset_hold%0d: got state=%0d en=%b expected 0 0000",
                         c, state_dbg, {pcwrite, irwrite, regwrite, memwrite});
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({state_dbg, irwrite, pcwrite, regwrite, memwrite} !== {FETCH_CODE, 4'b1100}) begin
            errors++;
            $display("[TB] FAIL mid_reset_release: got state=%0d irw,pcw,regw,memw=%b expected 0 1100",
                     state_dbg, {irwrite, pcwrite, regwrite, memwrite});
        end
    endtask

    task automatic test_lw();
        run_instr(OP_LW, 3'b010, 1'b0, 32'd0, 32'd4);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if ((obs_q[i] & exp_q[i].m) !== (exp_q[i].v & exp_q[i].m)) begin
                errors++;
                $display("[TB] FAIL lw cycle %0d: got %b expected %b mask %b",
                         i + 1, obs_q[i], exp_q[i].v, exp_q[i].m);
            end
        end
    endtask

    task automatic test_sub_addi();
        logic [6:0] ops [2];
        ops[0] = OP_R;
        ops[1] = OP_I;
        for (int k = 0; k < 2; k++) begin
            run_instr(ops[k], 3'b000, 1'b1, $urandom, $urandom);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if ((obs_q[i] & exp_q[i].m) !== (exp_q[i].v & exp_q[i].m)) begin
                    errors++;
                    $display("[TB] FAIL sub_addi op=%b cycle %0d: got %b expected %b mask %b",
                             ops[k], i + 1, obs_q[i], exp_q[i].v, exp_q[i].m);
                end
            end
        end
    endtask

    task automatic test_branch();
        logic [2:0]  f3 [4];
        logic [31:0] a  [4];
        logic [31:0] b  [4];
        f3[0] = 3'b100; a[0] = 32'd1;          b[0] = 32'd2;
        f3[1] = 3'b100; a[1] = 32'h7fff_ffff;  b[1] = 32'hffff_ffff;
        f3[2] = 3'b000; a[2] = 32'h1234_5678;  b[2] = 32'h1234_5678;
        f3[3] = 3'b101; a[3] = 32'h8000_0000;  b[3] = 32'd1;
        for (int k = 0; k < 4; k++) begin
            run_instr(OP_BR, f3[k], 1'b0, a[k], b[k]);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if ((obs_q[i] & exp_q[i].m) !== (exp_q[i].v & exp_q[i].m)) begin
                    errors++;
                    $display("[TB] FAIL branch%0d cycle %0d: got %b expected %b mask %b",
                             k, i + 1, obs_q[i], exp_q[i].v, exp_q[i].m);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [6:0] o [3];
        logic [2:0] f [3];
        o[0] = 7'b0000000; f[0] = 3'b000;
        o[1] = OP_R;       f[1] = 3'b001;
        o[2] = OP_BR;      f[2] = 3'b010;
        for (int k = 0; k < 3; k++) begin
            run_instr(o[k], f[k], 1'b0, 32'd5, 32'd5);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if ((obs_q[i] & exp_q[i].m) !== (exp_q[i].v & exp_q[i].m)) begin
                    errors++;
                    $display("[TB] FAIL illegal%0d cycle %0d: got %b expected %b mask %b",
                             k, i + 1, obs_q[i], exp_q[i].v, exp_q[i].m);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] o [6];
        logic [2:0] f [6];
        o[0] = OP_LW;  f[0] = 3'b010;
        o[1] = OP_SW;  f[1] = 3'b010;
        o[2] = OP_JAL; f[2] = 3'b000;
        o[3] = OP_BR;  f[3] = 3'b001;
        o[4] = OP_R;   f[4] = 3'b111;
        o[5] = OP_I;   f[5] = 3'b110;
        for (int k = 0; k < 6; k++) begin
            run_instr(o[k], f[k], 1'b0, 32'd7, 32'd9);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if ((obs_q[i] & exp_q[i].m) !== (exp_q[i].v & exp_q[i].m)) begin
                    errors++;
                    $display("[TB] FAIL back_to_back%0d cycle %0d: got %b expected %b mask %b",
                             k, i + 1, obs_q[i], exp_q[i].v, exp_q[i].m);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [6:0]  o;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0:       o = OP_LW;
                1:       o = OP_SW;
                2:       o = OP_R;
                3:       o = OP_I;
                4:       o = OP_BR;
                5:       o = OP_JAL;
                default: o = 7'($urandom);
            endcase
            f3 = 3'($urandom);
            f7 = 1'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_instr(o, f3, f7, a, b);
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if ((obs_q[i] & exp_q[i].m) !== (exp_q[i].v & exp_q[i].m)) begin
                    errors++;
                    $display("[TB] FAIL random%0d op=%b f3=%b cycle %0d: got %b expected %b mask %b",
                             n, o, f3, i + 1, obs_q[i], exp_q[i].v, exp_q[i].m);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        op       = 7'd0;
        funct3   = 3'd0;
        funct7b5 = 1'b0;
        bus.Z    = 1'b0;
        bus.N    = 1'b0;
        bus.C    = 1'b0;
        bus.V    = 1'b0;
        test_reset();
        test_sub_addi();
        test_lw();
        test_branch();
        test_illegal();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
